// File: rtl/basics_pkg.sv
// Shared types for the basics arithmetic library.
// Holds the state encoding used by the sequential multiplier.
package basics_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

endpackage

// File: rtl/adder_8bit.sv
// Combinational ripple-carry adder: {carry_out, sum} = a + b + carry_in.
// Built from explicit full-adder equations so the multiplier owns no '+' on its datapath.
module adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic w_c;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_c = carry_in;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        carry_out = w_c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready on both sides.
// One product bit per cycle through a single adder; product = {acc_hi, acc_lo}.
module shift_add_multiplier
    import basics_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_t       r_state;
    mul_state_t       w_state_next;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_last_step;

    adder_8bit #(.WIDTH(WIDTH)) u_adder (
        .a         (r_acc_hi),
        .b         (w_addend),
        .carry_in  (1'b0),
        .sum       (w_sum),
        .carry_out (w_cout)
    );

    assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_addend     = r_acc_lo[0] ? r_mcand : '0;
        w_state_next = r_state;
        case (r_state)
            MUL_IDLE: if (in_valid)   w_state_next = MUL_BUSY;
            MUL_BUSY: if (w_last_step) w_state_next = MUL_DONE;
            MUL_DONE: if (out_ready)  w_state_next = MUL_IDLE;
            default:                  w_state_next = MUL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= MUL_IDLE;
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == MUL_IDLE);
            r_out_valid <= (w_state_next == MUL_DONE);
            r_busy      <= (w_state_next == MUL_BUSY);
            case (r_state)
                MUL_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                    end
                end
                MUL_BUSY: begin
                    // Shift {carry, sum, acc_lo} right by one; the carry lands in acc_hi's MSB.
                    r_acc_hi <= {w_cout, w_sum[WIDTH-1:1]};
                    r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: transaction-level model checked every cycle
// plus directed vectors with hand-computed products, and a WIDTH=4 instance.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] product;
    logic          busy;

    logic          in_valid4 = 1'b0;
    logic          in_ready4;
    logic [3:0]    a4 = '0;
    logic [3:0]    b4 = '0;
    logic          out_valid4;
    logic          out_ready4 = 1'b1;
    logic [7:0]    product4;
    logic          busy4;

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_multiplier #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    shift_add_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one job outstanding from acceptance until its product is taken.
    bit          armed = 1'b0;
    bit          m_valid = 1'b0;
    int          cyc = 0;
    int          m_acc_cyc = 0;
    int          last_dut_acc = -1;
    int          n_done = 0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_last = '0;

    always @(negedge clk) begin
        bit exp_ov;
        cyc++;
        exp_ov = m_valid && ((cyc - m_acc_cyc) >= W + 1);
        if (armed) begin
            check("mdl_in_ready",  32'(in_ready),  32'(!m_valid));
            check("mdl_out_valid", 32'(out_valid), 32'(exp_ov));
            check("mdl_busy",      32'(busy),      32'(m_valid && !exp_ov));
            if (exp_ov)
                check("mdl_product", 32'(product), 32'(m_prod));
            else if (!m_valid)
                check("mdl_idle_product", 32'(product), 32'(m_last));
            if (in_valid && in_ready && !rst) begin
                if (last_dut_acc >= 0)
                    check("acc_spacing", 32'((cyc - last_dut_acc) >= W + 2), 32'd1);
                last_dut_acc = cyc;
            end
        end
        if (rst) begin
            armed        = 1'b1;
            m_valid      = 1'b0;
            m_last       = '0;
            last_dut_acc = -1;
        end else if (m_valid && exp_ov && out_ready) begin
            m_valid = 1'b0;
            m_last  = m_prod;
            n_done++;
        end else if (!m_valid && in_valid) begin
            m_valid   = 1'b1;
            m_acc_cyc = cyc;
            m_prod    = 16'(a) * 16'(b);
        end
    end

    // Called at posedge+#1: present operands, wait for acceptance, measure latency, check result.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp_p, input string name, input bit do_ack);
        int n;
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_in_ready_drop"}, 32'(in_ready), 32'd0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 100);
        check({name, "_latency"}, 32'(n), 32'd8);
        check({name, "_product"}, 32'(product), 32'(exp_p));
        if (do_ack) begin
            @(posedge clk); #1;
            check({name, "_back_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_product",   32'(product),   32'd0);

        run_op(8'd13,  8'd11,  16'h008F, "m13x11",   1'b1);
        run_op(8'd255, 8'd255, 16'hFE01, "m255x255", 1'b1);
        run_op(8'd0,   8'd200, 16'h0000, "m0x200",   1'b1);
        run_op(8'd200, 8'd1,   16'h00C8, "m200x1",   1'b1);
        check("idle_product_held", 32'(product), 32'h00C8);

        // Backpressure in DONE with noisy operand inputs.
        out_ready = 1'b0;
        run_op(8'd7, 8'd9, 16'h003F, "bp7x9", 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_product",   32'(product),   32'h003F);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle",    32'(in_ready), 32'd1);
        check("bp_release_product", 32'(product),  32'h003F);

        // Reset after step 4 of 100*100.
        in_valid = 1'b1;
        a = 8'd100;
        b = 8'd100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy",      32'(busy),      32'd0);
        check("rst_mid_product",   32'(product),   32'd0);
        run_op(8'd3, 8'd5, 16'h000F, "m3x5", 1'b1);

        // Back-to-back random traffic; the model process scores each result.
        begin
            int start_done;
            start_done = n_done;
            in_valid = 1'b1;
            n = 0;
            while ((n_done - start_done) < 200 && n < 20000) begin
                a = 8'($urandom);
                b = 8'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            check("b2b_completed", 32'(n_done - start_done >= 200), 32'd1);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            check("b2b_drain_idle", 32'(in_ready), 32'd1);
        end

        // WIDTH=4 instance.
        in_valid4 = 1'b1;
        a4 = 4'd15;
        b4 = 4'd15;
        check("w4_ready", 32'(in_ready4), 32'd1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid4 && n < 100);
        check("w4_latency", 32'(n), 32'd4);
        check("w4_product", 32'(product4), 32'h00E1);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
